csma_backoff: RTL and testbench

CSMA/CA channel-access engine for the xpu transmit path. It consumes the `ch_idle` level produced by the clear-channel-assessment stage and decides when a pending frame may be sent. It enforces an inter-frame space (IFS/AIFS), then a random slotted backoff that freezes while the channel is busy. It issues a one-cycle `tx_grant` to the tx controller and adapts the contention window from the tx outcome.

---
 rtl/xpu_csma_pkg.sv | 24 ++
 rtl/backoff_lfsr.sv | 18 +
 rtl/csma_backoff.sv | 179 +++++++++++++++++
 tb/tb_csma_backoff.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xpu_csma_pkg.sv
// Shared definitions for the CSMA/CA channel-access engine: state encoding,
// LFSR polynomial and default widths.
package xpu_csma_pkg;

  localparam int          SLOT_W_DEF    = 12;
  localparam int          IFS_W_DEF     = 14;
  localparam int          BO_W_DEF      = 10;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IFS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_WAIT_TX = 2'd3
  } csma_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/backoff_lfsr.sv
// Free-running 16-bit Galois LFSR used as the backoff random source.
// Advances every cycle, one-cycle latency, never stalls.
module backoff_lfsr
  import xpu_csma_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

endmodule

// File: rtl/csma_backoff.sv
// CSMA/CA access engine: IFS, slotted backoff frozen by busy channel, CW adaptation.
// Registered outputs; grant lands the cycle after the last required idle cycle; tx_req low aborts contention.
module csma_backoff
  import xpu_csma_pkg::*;
#(
  parameter int          SLOT_W    = SLOT_W_DEF,
  parameter int          IFS_W     = IFS_W_DEF,
  parameter int          BO_W      = BO_W_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ch_idle,
  input  logic [SLOT_W-1:0] slot_cycles,
  input  logic [IFS_W-1:0]  ifs_cycles,
  input  logic [3:0]        cw_min_exp,
  input  logic [3:0]        cw_max_exp,
  input  logic [3:0]        retry_limit,
  input  logic              tx_req,
  input  logic              tx_done,
  input  logic              tx_fail,
  output logic              tx_grant,
  output logic              drop,
  output logic [BO_W-1:0]   backoff_remaining,
  output logic [3:0]        cw_exp,
  output logic [1:0]        state
);

  localparam logic [IFS_W-1:0]  IFS_ONE  = 1;
  localparam logic [SLOT_W-1:0] SLOT_ONE = 1;
  localparam logic [BO_W-1:0]   BO_ONE   = 1;

  csma_state_t       state_q, state_d;
  logic [IFS_W-1:0]  ifs_cnt, ifs_cnt_d, ifs_len;
  logic [SLOT_W-1:0] slot_cnt, slot_cnt_d, slot_len;
  logic [BO_W-1:0]   bo_d;
  logic [3:0]        cw_d, cw_fail, retry_cnt, retry_d;
  logic [4:0]        cw_up;
  logic              residual_valid, resid_d;
  logic              grant_d, drop_d, grant_now, retry_over;
  logic              ifs_hit, slot_hit;
  logic [15:0]       lfsr;
  logic              lfsr_unused;

  backoff_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .lfsr (lfsr)
  );

  // Only the low BO_W bits feed the draw.
  assign lfsr_unused = ^lfsr;

  // Mask keeps the low min(e, BO_W) bits of the random word.
  function automatic logic [BO_W-1:0] draw(input logic [BO_W-1:0] rnd, input logic [3:0] e);
    logic [BO_W-1:0] m;
    for (int i = 0; i < BO_W; i++) m[i] = (i < int'(e));
    return rnd & m;
  endfunction

  assign ifs_len    = (ifs_cycles == '0) ? IFS_ONE : ifs_cycles;
  assign slot_len   = (slot_cycles == '0) ? SLOT_ONE : slot_cycles;
  assign ifs_hit    = (ifs_cnt == ifs_len - IFS_ONE);
  assign slot_hit   = (slot_cnt == slot_len - SLOT_ONE);
  assign cw_up      = {1'b0, cw_exp} + 5'd1;
  assign cw_fail    = (cw_up > {1'b0, cw_max_exp}) ? cw_max_exp : cw_up[3:0];
  assign retry_over = ({1'b0, retry_cnt} + 5'd1) > {1'b0, retry_limit};

  always_comb begin
    state_d    = state_q;
    ifs_cnt_d  = ifs_cnt;
    slot_cnt_d = slot_cnt;
    bo_d       = backoff_remaining;
    cw_d       = cw_exp;
    retry_d    = retry_cnt;
    resid_d    = residual_valid;
    grant_d    = 1'b0;
    drop_d     = 1'b0;
    grant_now  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (retry_cnt == 4'd0) cw_d = cw_min_exp;
        if (tx_req) begin
          // A frozen residual from an earlier attempt is resumed, not redrawn.
          if (!residual_valid) begin
            bo_d    = draw(lfsr[BO_W-1:0], cw_d);
            resid_d = 1'b1;
          end
          state_d   = ST_IFS;
          ifs_cnt_d = '0;
        end
      end
      ST_IFS: begin
        if (!tx_req) begin
          state_d = ST_IDLE;
        end else if (!ch_idle) begin
          ifs_cnt_d = '0;
        end else if (ifs_hit) begin
          ifs_cnt_d = '0;
          if (backoff_remaining != '0) begin
            state_d    = ST_BACKOFF;
            slot_cnt_d = '0;
          end else begin
            grant_now = 1'b1;
          end
        end else begin
          ifs_cnt_d = ifs_cnt + IFS_ONE;
        end
      end
      ST_BACKOFF: begin
        if (!tx_req) begin
          state_d    = ST_IDLE;
          slot_cnt_d = '0;
        end else if (!ch_idle) begin
          // Freeze: partial slot is lost, the full IFS must be observed again.
          state_d    = ST_IFS;
          ifs_cnt_d  = '0;
          slot_cnt_d = '0;
        end else if (slot_hit) begin
          slot_cnt_d = '0;
          bo_d       = backoff_remaining - BO_ONE;
          grant_now  = (backoff_remaining == BO_ONE);
        end else begin
          slot_cnt_d = slot_cnt + SLOT_ONE;
        end
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          if (!tx_fail || retry_over) begin
            retry_d = 4'd0;
            cw_d    = cw_min_exp;
            drop_d  = tx_fail;
          end else begin
            retry_d = retry_cnt + 4'd1;
            cw_d    = cw_fail;
          end
          bo_d    = draw(lfsr[BO_W-1:0], cw_d);
          resid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_now) begin
      grant_d = 1'b1;
      resid_d = 1'b0;
      state_d = ST_WAIT_TX;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= ST_IDLE;
      ifs_cnt           <= '0;
      slot_cnt          <= '0;
      backoff_remaining <= '0;
      cw_exp            <= 4'd0;
      retry_cnt         <= 4'd0;
      residual_valid    <= 1'b0;
      tx_grant          <= 1'b0;
      drop              <= 1'b0;
    end else begin
      state_q           <= state_d;
      ifs_cnt           <= ifs_cnt_d;
      slot_cnt          <= slot_cnt_d;
      backoff_remaining <= bo_d;
      cw_exp            <= cw_d;
      retry_cnt         <= retry_d;
      residual_valid    <= resid_d;
      tx_grant          <= grant_d;
      drop              <= drop_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_csma_backoff.sv
// Bench for csma_backoff: directed scenarios plus random traffic, all checked
// against a contention model expressed as idle-run arithmetic.
module tb_csma_backoff;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ch_idle = 1'b0, tx_req = 1'b0, tx_done = 1'b0, tx_fail = 1'b0;
  logic [11:0] slot_cycles = 12'd4;
  logic [13:0] ifs_cycles = 14'd10;
  logic [3:0]  cw_min_exp = 4'd0, cw_max_exp = 4'd4, retry_limit = 4'd3;
  logic        tx_grant, drop;
  logic [9:0]  backoff_remaining;
  logic [3:0]  cw_exp;
  logic [1:0]  state;

  always #5 clk = ~clk;

  csma_backoff #(.SLOT_W(12), .IFS_W(14), .BO_W(10), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rstn(rstn), .ch_idle(ch_idle), .slot_cycles(slot_cycles),
    .ifs_cycles(ifs_cycles), .cw_min_exp(cw_min_exp), .cw_max_exp(cw_max_exp),
    .retry_limit(retry_limit), .tx_req(tx_req), .tx_done(tx_done), .tx_fail(tx_fail),
    .tx_grant(tx_grant), .drop(drop), .backoff_remaining(backoff_remaining),
    .cw_exp(cw_exp), .state(state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model: phase 0 = no frame, 1 = contending, 2 = frame on air.
  // While contending, run counts unbroken idle cycles since IFS (re)start and
  // b0 is the backoff held at the start of that run.
  int          m_phase, m_run, m_b0, m_retry, m_cw;
  bit          m_resid, m_grant, m_drop;
  logic [15:0] m_lf;
  int          ifs_e, slot_e;
  int          cyc, grant_cyc;

  function automatic int draw_m(input logic [15:0] lf, input int e);
    int k = (e > 10) ? 10 : e;
    return (int'(lf) % 1024) % (1 << k);
  endfunction

  function automatic int done_slots();
    return (m_run > ifs_e) ? (m_run - ifs_e) / slot_e : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_b0 = 0; m_retry = 0; m_cw = 0;
    m_resid = 0; m_grant = 0; m_drop = 0; m_lf = 16'hACE1;
  endtask

  task automatic model_edge(input bit req, input bit idle, input bit done, input bit fail);
    m_grant = 0;
    m_drop  = 0;
    case (m_phase)
      0: begin
        if (m_retry == 0) m_cw = int'(cw_min_exp);
        if (req) begin
          if (!m_resid) begin
            m_b0 = draw_m(m_lf, m_cw);
            m_resid = 1;
          end
          m_phase = 1;
          m_run = 0;
        end
      end
      1: begin
        if (!req || !idle) begin
          m_b0 = m_b0 - done_slots();
          m_run = 0;
          if (!req) m_phase = 0;
        end else begin
          m_run++;
          if (m_run == ifs_e + m_b0 * slot_e) begin
            m_grant = 1; m_phase = 2; m_resid = 0; m_b0 = 0; m_run = 0;
          end
        end
      end
      default: begin
        if (done) begin
          if (fail && (m_retry + 1 > int'(retry_limit))) begin
            m_drop = 1; m_retry = 0; m_cw = int'(cw_min_exp);
          end else if (fail) begin
            m_retry++;
            m_cw = (m_cw + 1 > int'(cw_max_exp)) ? int'(cw_max_exp) : m_cw + 1;
          end else begin
            m_retry = 0; m_cw = int'(cw_min_exp);
          end
          m_b0 = draw_m(m_lf, m_cw);
          m_resid = 1;
          m_phase = 0;
        end
      end
    endcase
    m_lf = m_lf[0] ? ((m_lf >> 1) ^ 16'hB400) : (m_lf >> 1);
  endtask

  task automatic compare(input string tag);
    int exp_state, exp_bo;
    exp_state = (m_phase == 0) ? 0 : (m_phase == 2) ? 3 : ((m_run < ifs_e) ? 1 : 2);
    exp_bo    = (m_phase == 1) ? m_b0 - done_slots() : m_b0;
    check({tag, ".state"}, 32'(state), exp_state);
    check({tag, ".grant"}, 32'(tx_grant), 32'(m_grant));
    check({tag, ".drop"},  32'(drop), 32'(m_drop));
    check({tag, ".bo"},    32'(backoff_remaining), exp_bo);
    check({tag, ".cw"},    32'(cw_exp), m_cw);
  endtask

  task automatic step(input bit req, input bit idle, input bit done, input bit fail);
    tx_req = req; ch_idle = idle; tx_done = done; tx_fail = fail;
    ifs_e  = (ifs_cycles == 0) ? 1 : int'(ifs_cycles);
    slot_e = (slot_cycles == 0) ? 1 : int'(slot_cycles);
    @(posedge clk);
    model_edge(req, idle, done, fail);
    cyc++;
    #1;
    compare("cyc");
    if (tx_grant === 1'b1) grant_cyc = cyc;
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #1;
    model_reset();
    compare(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic cfg(input int ifs, input int slot, input int cmin, input int cmax, input int rl);
    ifs_cycles = 14'(ifs); slot_cycles = 12'(slot);
    cw_min_exp = 4'(cmin); cw_max_exp = 4'(cmax); retry_limit = 4'(rl);
    ifs_e  = (ifs == 0) ? 1 : ifs;
    slot_e = (slot == 0) ? 1 : slot;
  endtask

  task automatic run_frame(input bit fail, input int want_cw, input string tag);
    grant_cyc = -1;
    for (int i = 0; i < 1000 && grant_cyc < 0; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, fail);
    check(tag, 32'(cw_exp), want_cw);
  endtask

  initial begin
    #2;
    // Zero backoff on a quiet channel.
    cfg(10, 4, 0, 4, 3);
    do_reset("rst0");
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    cyc = 0; grant_cyc = -1;
    for (int i = 0; i < 60 && grant_cyc < 0; i++) step(1, 1, 0, 0);
    check("zero_bo_grant_cyc", grant_cyc, 11);
    check("zero_bo_state", 32'(state), 3);
    step(0, 1, 1, 0);

    // Three-slot backoff, quiet channel.
    cfg(10, 4, 2, 4, 3);
    do_reset("rst_b3");
    for (int i = 0; i < 64 && m_lf[1:0] != 2'b11; i++) step(0, 1, 0, 0);
    cyc = 0; grant_cyc = -1;
    step(1, 1, 0, 0);
    check("b3_draw", 32'(backoff_remaining), 3);
    for (int i = 0; i < 60 && grant_cyc < 0; i++) step(1, 1, 0, 0);
    check("b3_grant_cyc", grant_cyc, 23);
    step(0, 1, 1, 0);

    // Same, with a 5-cycle busy burst in the middle of the second slot.
    do_reset("rst_frz");
    for (int i = 0; i < 64 && m_lf[1:0] != 2'b11; i++) step(0, 1, 0, 0);
    cyc = 0; grant_cyc = -1;
    for (int i = 0; i < 100 && grant_cyc < 0; i++) begin
      step(1, !(cyc >= 17 && cyc <= 21), 0, 0);
      if (cyc == 20) begin
        check("frz_bo_held", 32'(backoff_remaining), 2);
        check("frz_state_ifs", 32'(state), 1);
      end
    end
    check("frz_grant_cyc", grant_cyc, 40);
    step(0, 1, 1, 0);

    // Retry escalation and recovery.
    cfg(3, 2, 4, 6, 7);
    do_reset("rst_retry");
    run_frame(1, 5, "retry1_cw");
    run_frame(1, 6, "retry2_cw");
    run_frame(1, 6, "retry3_cw");
    run_frame(0, 4, "retry_ok_cw");
    cw_min_exp = 4'd3;
    step(0, 1, 0, 0);
    check("retry_cleared_tracks_min", 32'(cw_exp), 3);

    // Retry limit exceeded.
    cfg(3, 2, 2, 5, 1);
    do_reset("rst_drop");
    run_frame(1, 3, "drop1_cw");
    check("drop1_no_pulse", 32'(drop), 0);
    run_frame(1, 2, "drop2_cw");
    check("drop2_pulse", 32'(drop), 1);

    // Withdraw during backoff, then resume without a new draw.
    cfg(10, 4, 3, 4, 3);
    do_reset("rst_wd");
    for (int i = 0; i < 64 && m_lf[2:0] != 3'd5; i++) step(0, 1, 0, 0);
    cyc = 0;
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("wd_state_idle", 32'(state), 0);
    check("wd_bo_kept", 32'(backoff_remaining), 5);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    cyc = 0; grant_cyc = -1;
    step(1, 1, 0, 0);
    check("wd_resume_bo", 32'(backoff_remaining), 5);
    for (int i = 0; i < 60 && grant_cyc < 0; i++) step(1, 1, 0, 0);
    check("wd_grant_cyc", grant_cyc, 31);
    step(0, 1, 1, 0);

    // Asynchronous reset in the middle of a backoff.
    for (int i = 0; i < 64 && m_lf[2:0] != 3'd6; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    check("rst_mid_in_backoff", 32'(state), 2);
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // Random traffic against the model.
    for (int blk = 0; blk < 8; blk++) begin
      cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 4),
          $urandom_range(0, 6), $urandom_range(0, 3));
      do_reset("rnd_rst");
      for (int i = 0; i < 500; i++) begin
        bit r, id, d, f;
        id = ($urandom_range(0, 9) < 8);
        if (m_phase == 0)      r = ($urandom_range(0, 9) < 4);
        else if (m_phase == 1) r = ($urandom_range(0, 99) >= 3);
        else                   r = 1'($urandom_range(0, 1));
        d = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
        f = 1'($urandom_range(0, 1));
        step(r, id, d, f);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
